// File: rtl/idct_1d.sv
// rtl/idct_1d.sv - pipelined 8-point 1-D inverse DCT with valid/ready handshake
// Purpose: three register stages (butterfly, constant multiply, recombine/round)
//          turning 8 signed coefficients into 8 signed spatial samples.
// Config : define IDCT_SAT_EN to clamp each sample to the OUT_W range and report
//          clipping on sat; when undefined samples wrap to OUT_W bits and sat is 0.
// Ports  : clk, rst (async, active-high)
//          in_valid/in_ready, X0..X7  (IN_W signed coefficients, X0 = DC)
//          out_valid/out_ready, x0..x7 (OUT_W signed samples), sat
module idct_1d #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 9,
    parameter int ACC_W = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  X0,
    input  logic signed [IN_W-1:0]  X1,
    input  logic signed [IN_W-1:0]  X2,
    input  logic signed [IN_W-1:0]  X3,
    input  logic signed [IN_W-1:0]  X4,
    input  logic signed [IN_W-1:0]  X5,
    input  logic signed [IN_W-1:0]  X6,
    input  logic signed [IN_W-1:0]  X7,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] x0,
    output logic signed [OUT_W-1:0] x1,
    output logic signed [OUT_W-1:0] x2,
    output logic signed [OUT_W-1:0] x3,
    output logic signed [OUT_W-1:0] x4,
    output logic signed [OUT_W-1:0] x5,
    output logic signed [OUT_W-1:0] x6,
    output logic signed [OUT_W-1:0] x7,
    output logic                    sat
);
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam acc_t K6  = acc_t'(6);
    localparam acc_t K12 = acc_t'(12);
    localparam acc_t K18 = acc_t'(18);
    localparam acc_t K23 = acc_t'(23);
    localparam acc_t K27 = acc_t'(27);
    localparam acc_t K30 = acc_t'(30);
    localparam acc_t K31 = acc_t'(31);
    localparam acc_t RND = acc_t'(32);

    // Whole pipeline moves together: any stage may advance only if the output
    // register is empty or being drained this cycle.
    logic out_valid_q;
    logic adv;
    assign adv       = !out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;

    // Stage 1: DC/X4 butterfly, other coefficients pass through
    logic                   v1_q;
    acc_t                   s0_q, s1_q, s0_d, s1_d;
    logic signed [IN_W-1:0] c1_q, c2_q, c3_q, c5_q, c6_q, c7_q;

    assign s0_d = acc_t'(X0) + acc_t'(X4);
    assign s1_d = acc_t'(X0) - acc_t'(X4);

    // Stage 2: even and odd partial products
    acc_t w1, w2, w3, w5, w6, w7;
    logic v2_q;
    acc_t e_d [4];
    acc_t e_q [4];
    acc_t o_d [4];
    acc_t o_q [4];

    assign w1 = acc_t'(c1_q);
    assign w2 = acc_t'(c2_q);
    assign w3 = acc_t'(c3_q);
    assign w5 = acc_t'(c5_q);
    assign w6 = acc_t'(c6_q);
    assign w7 = acc_t'(c7_q);

    always_comb begin
        e_d[0] = K23 * s0_q;
        e_d[1] = K23 * s1_q;
        e_d[2] = K30 * w2 + K12 * w6;
        e_d[3] = K12 * w2 - K30 * w6;
        o_d[0] = K31 * w1 + K27 * w3 + K18 * w5 + K6  * w7;
        o_d[1] = K27 * w1 - K6  * w3 - K31 * w5 - K18 * w7;
        o_d[2] = K18 * w1 - K31 * w3 + K6  * w5 + K27 * w7;
        o_d[3] = K6  * w1 - K18 * w3 + K27 * w5 - K31 * w7;
    end

    // Stage 3: recombine, round half-up by 1/64, reduce to OUT_W
    acc_t                    ev [4];
    acc_t                    a  [8];
    logic signed [OUT_W-1:0] y_d [8];
    logic signed [OUT_W-1:0] y_q [8];

    always_comb begin
        ev[0] = e_q[0] + e_q[2];
        ev[1] = e_q[1] + e_q[3];
        ev[2] = e_q[1] - e_q[3];
        ev[3] = e_q[0] - e_q[2];
        for (int n = 0; n < 4; n++) begin
            a[n]     = ev[n] + o_q[n];
            a[7 - n] = ev[n] - o_q[n];
        end
    end

`ifdef IDCT_SAT_EN
    localparam logic signed [OUT_W-1:0] YMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] YMIN = {1'b1, {(OUT_W-1){1'b0}}};

    acc_t rnd [8];
    logic sat_d, sat_q;

    always_comb begin
        sat_d = 1'b0;
        for (int n = 0; n < 8; n++) begin
            rnd[n] = (a[n] + RND) >>> 6;
            if (rnd[n] > acc_t'(YMAX)) begin
                y_d[n] = YMAX;
                sat_d  = 1'b1;
            end else if (rnd[n] < acc_t'(YMIN)) begin
                y_d[n] = YMIN;
                sat_d  = 1'b1;
            end else begin
                y_d[n] = OUT_W'(rnd[n]);
            end
        end
    end

    assign sat = sat_q;
`else
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            y_d[n] = OUT_W'((a[n] + RND) >>> 6);
        end
    end

    assign sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s0_q        <= '0;
            s1_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            c3_q        <= '0;
            c5_q        <= '0;
            c6_q        <= '0;
            c7_q        <= '0;
            for (int n = 0; n < 4; n++) begin
                e_q[n] <= '0;
                o_q[n] <= '0;
            end
            for (int n = 0; n < 8; n++) begin
                y_q[n] <= '0;
            end
`ifdef IDCT_SAT_EN
            sat_q <= 1'b0;
`endif
        end else if (adv) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            c1_q        <= X1;
            c2_q        <= X2;
            c3_q        <= X3;
            c5_q        <= X5;
            c6_q        <= X6;
            c7_q        <= X7;
            for (int n = 0; n < 4; n++) begin
                e_q[n] <= e_d[n];
                o_q[n] <= o_d[n];
            end
            for (int n = 0; n < 8; n++) begin
                y_q[n] <= y_d[n];
            end
`ifdef IDCT_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

    assign x0 = y_q[0];
    assign x1 = y_q[1];
    assign x2 = y_q[2];
    assign x3 = y_q[3];
    assign x4 = y_q[4];
    assign x5 = y_q[5];
    assign x6 = y_q[6];
    assign x7 = y_q[7];

endmodule

// File: tb/tb_idct_1d.sv
// tb/tb_idct_1d.sv - self-checking bench for idct_1d (cosine-matrix model + directed vectors)
module tb_idct_1d;
    localparam int IN_W  = 12;
    localparam int OUT_W = 9;
    localparam int ACC_W = 22;
    localparam int YMAXI = (1 << (OUT_W - 1)) - 1;
    localparam int YMINI = -(1 << (OUT_W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, sat;
    logic signed [IN_W-1:0]  X0 = '0, X1 = '0, X2 = '0, X3 = '0;
    logic signed [IN_W-1:0]  X4 = '0, X5 = '0, X6 = '0, X7 = '0;
    logic signed [OUT_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic signed [OUT_W-1:0] xo [8];

    idct_1d #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .X0(X0), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5), .X6(X6), .X7(X7),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .sat(sat)
    );

    assign xo[0] = x0; assign xo[1] = x1; assign xo[2] = x2; assign xo[3] = x3;
    assign xo[4] = x4; assign xo[5] = x5; assign xo[6] = x6; assign xo[7] = x7;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: x[n] = round_half_up(sum_k M[n][k]*X[k] / 64), M[n][k] = round(32*C(k)*cos((2n+1)k*pi/16))
    int M [8][8];

    typedef struct {
        int x [8];
        int s;
    } exp_t;

    task automatic model(input int v [8], output exp_t e);
        int acc, y, w;
        e.s = 0;
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) acc += M[n][k] * v[k];
            y = (acc + 32) >>> 6;
`ifdef IDCT_SAT_EN
            if (y > YMAXI) begin y = YMAXI; e.s = 1; end
            if (y < YMINI) begin y = YMINI; e.s = 1; end
`else
            w = y & ((1 << OUT_W) - 1);
            if (w > YMAXI) w -= (1 << OUT_W);
            y = w;
`endif
            e.x[n] = y;
        end
    endtask

    // Scoreboard: push on accept, pop and compare on every output transfer,
    // and check that a stalled output does not move.
    exp_t q [$];
    int   held [9];
    bit   held_valid = 1'b0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            held_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                int   v [8];
                exp_t e;
                v[0] = int'(X0); v[1] = int'(X1); v[2] = int'(X2); v[3] = int'(X3);
                v[4] = int'(X4); v[5] = int'(X5); v[6] = int'(X6); v[7] = int'(X7);
                model(v, e);
                q.push_back(e);
            end
            if (out_valid) begin
                if (held_valid) begin
                    for (int n = 0; n < 8; n++) chk($sformatf("hold_x%0d", n), int'(xo[n]), held[n]);
                    chk("hold_sat", int'(sat), held[8]);
                end
                if (out_ready) begin
                    held_valid = 1'b0;
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected_output: got out_valid=1 expected no pending vector at %0t", $time);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        for (int n = 0; n < 8; n++) chk($sformatf("sb_x%0d", n), int'(xo[n]), e.x[n]);
                        chk("sb_sat", int'(sat), e.s);
                    end
                end else begin
                    for (int n = 0; n < 8; n++) held[n] = int'(xo[n]);
                    held[8] = int'(sat);
                    held_valid = 1'b1;
                end
            end
        end
    end

    task automatic drive(input int v [8]);
        X0 = IN_W'(v[0]); X1 = IN_W'(v[1]); X2 = IN_W'(v[2]); X3 = IN_W'(v[3]);
        X4 = IN_W'(v[4]); X5 = IN_W'(v[5]); X6 = IN_W'(v[6]); X7 = IN_W'(v[7]);
    endtask

    // Starts and ends just after a rising edge; out_ready must be 1.
    task automatic run_single(input string nm, input int v [8], input int ex [8], input int es);
        drive(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat1"}, int'(out_valid), 0);
        @(posedge clk); #1;
        chk({nm, "_lat2"}, int'(out_valid), 0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, int'(out_valid), 1);
        for (int n = 0; n < 8; n++) chk($sformatf("%s_x%0d", nm, n), int'(xo[n]), ex[n]);
        chk({nm, "_sat"}, int'(sat), es);
        @(posedge clk); #1;
        chk({nm, "_one_cycle"}, int'(out_valid), 0);
    endtask

    int dc  [8] = '{64, 0, 0, 0, 0, 0, 0, 0};
    int dcx [8] = '{23, 23, 23, 23, 23, 23, 23, 23};
    int ac1 [8] = '{0, 64, 0, 0, 0, 0, 0, 0};
    int acx [8] = '{31, 27, 18, 6, -6, -18, -27, -31};
    int ovf [8] = '{2047, 0, 0, 0, 0, 0, 0, 0};
`ifdef IDCT_SAT_EN
    int ovx [8] = '{255, 255, 255, 255, 255, 255, 255, 255};
    int ovs = 1;
`else
    int ovx [8] = '{224, 224, 224, 224, 224, 224, 224, 224};
    int ovs = 0;
`endif
    int bp [5][8] = '{
        '{64, 0, 0, 0, 0, 0, 0, 0},
        '{-100, 50, 0, -30, 20, 7, -3, 11},
        '{300, -200, 120, 45, -60, 33, 80, -19},
        '{-2048, 2047, -1000, 500, 1500, -700, 250, -2048},
        '{5, -5, 17, -17, 99, -99, 1, -1}
    };
    int pat [6] = '{1, 0, 1, 1, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        real pi, r, ck;
        int  idx;
        bit  acc;
        pi = 3.14159265358979;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 8; k++) begin
                ck = (k == 0) ? 0.70710678118655 : 1.0;
                r  = 32.0 * ck * $cos(real'((2 * n + 1) * k) * pi / 16.0);
                M[n][k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
            end
        end
        // pin the generated matrix to the hand-rounded constants
        chk("model_m00", M[0][0], 23);
        chk("model_m01", M[0][1], 31);
        chk("model_m12", M[1][2], 12);
        chk("model_m73", M[7][3], -27);

        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x0", int'(x0), 0);
        chk("rst_x7", int'(x7), 0);
        chk("rst_sat", int'(sat), 0);
        #9 rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        run_single("dc", dc, dcx, 0);
        run_single("ac1", ac1, acx, 0);
        run_single("ovf", ovf, ovx, ovs);

        // backpressure: 5 back-to-back vectors, output stalled for 4 clocks
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (idx < 5) begin
                drive(bp[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            if (c >= 3 && c <= 6) begin
                chk("bp_in_ready_low", int'(in_ready), 0);
                chk("bp_out_valid_held", int'(out_valid), 1);
                chk("bp_frozen_x0", int'(x0), 23);
            end
            if (c >= 7 && c <= 11) chk("bp_consecutive", int'(out_valid), 1);
            if (c == 12) chk("bp_drained", int'(out_valid), 0);
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_all_accepted", idx, 5);
        out_ready = 1'b1;

        // bubbles: out_valid pattern equals in_valid pattern shifted 3 clocks
        for (int c = 0; c < 10; c++) begin
            drive(bp[c % 5]);
            in_valid = (c < 6) ? pat[c][0] : 1'b0;
            #1;
            chk($sformatf("bubble_c%0d", c), int'(out_valid), (c >= 3 && c < 9) ? pat[c - 3] : 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // reset mid-operation with 3 vectors in flight
        for (int c = 0; c < 3; c++) begin
            drive(bp[c + 1]);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("midrst_full", int'(out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        for (int n = 0; n < 8; n++) chk($sformatf("midrst_x%0d", n), int'(xo[n]), 0);
        chk("midrst_sat", int'(sat), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_single("post_rst", ac1, acx, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idct_1d.md
Name: idct_1d

Overview:
- Pipelined 8-point 1-D inverse DCT; the decoder-side counterpart of the forward 8-point row/column DCT stage.
- Takes 8 dequantized signed coefficients X0..X7 in parallel and produces 8 spatial samples x0..x7 in parallel.
- Used twice in the JPEG decode path: a row pass and a column pass, with a transpose buffer between them.
- Valid/ready handshake on both sides, with full-pipeline stall on backpressure.

Parameters:
- IN_W, 12, signed width of each input coefficient.
- OUT_W, 9, signed width of each output sample.
- ACC_W, 22, internal signed accumulator width. Must be >= IN_W+10.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  X0..X7 carry a valid vector.
- in_ready  output  1  block accepts the vector this cycle.
- X0..X7  input  IN_W each  signed DCT coefficients; X0 is DC.
- out_valid  output  1  x0..x7 hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- x0..x7  output  OUT_W each  signed reconstructed samples.
- sat  output  1  result currently presented was clipped (see Optional Feature).

Behaviour:
- Reset: async, active-high. All pipeline registers, x0..x7, out_valid and sat go to 0 immediately. in_ready is 1 once rst deasserts.
- Advance enable: adv = !out_valid | out_ready.
  - in_ready = adv, combinational.
  - A transfer occurs when in_valid & in_ready.
  - All stage registers and their valid bits update only when adv=1; otherwise they hold.
- Latency: exactly 3 clocks from the accepting edge to out_valid=1, with no stall. Throughput is 1 vector/clock. Bubbles propagate as valid=0.
- Output hold: while out_valid=1 and out_ready=0, x0..x7, sat and out_valid hold stable.
- Stage 1 (register):
  - s0 = X0+X4, s1 = X0-X4.
  - Register X1, X2, X3, X5, X6, X7 unchanged.
- Stage 2 (register). Coefficients are 64*C(k)/2*cos(...), rounded.
  - e0 = 23*s0, e1 = 23*s1.
  - e2 = 30*X2 + 12*X6, e3 = 12*X2 - 30*X6.
  - O0 = 31X1 + 27X3 + 18X5 + 6X7.
  - O1 = 27X1 - 6X3 - 31X5 - 18X7.
  - O2 = 18X1 - 31X3 + 6X5 + 27X7.
  - O3 = 6X1 - 18X3 + 27X5 - 31X7.
- Stage 3 (register to outputs):
  - E0 = e0+e2, E1 = e1+e3, E2 = e1-e3, E3 = e0-e2.
  - a[n] = E[n]+O[n] for x[n], n = 0..3.
  - a[7-n] = E[n]-O[n] for x[7-n].
  - Each result: y = (a + 32) >>> 6, arithmetic shift, i.e. round-half-up.
  - Then reduce to OUT_W per Optional Feature.
- All arithmetic is signed at ACC_W. No internal overflow is possible for IN_W <= 12.
- Simultaneous events:
  - An accept and an output drain in the same cycle are legal; the pipeline shifts by one.
  - rst overrides everything.
  - Reset mid-operation discards all in-flight vectors; nothing is replayed.

Optional Feature:
- Macro: IDCT_SAT_EN.
- Defined:
  - y is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat is registered with the outputs and is 1 if any of the 8 lanes clamped.
- Undefined:
  - x[n] = y[OUT_W-1:0], two's-complement wrap.
  - sat is tied to 0.
  - No clamp logic is present.

Test Plan:
- DC: X0=64, others 0, out_ready=1 -> after 3 clocks out_valid=1 for 1 cycle, x0..x7 all = 23, sat=0.
- AC1: X1=64, others 0 -> x0..x7 = 31, 27, 18, 6, -6, -18, -27, -31.
- Overflow: X0=2047, others 0, OUT_W=9:
  - With IDCT_SAT_EN: all x = 255, sat=1.
  - Without IDCT_SAT_EN: all x = 224, sat=0.
- Backpressure:
  - Stream 5 vectors back-to-back.
  - Hold out_ready=0 from the first out_valid for 4 clocks -> in_ready=0, outputs frozen on vector 1.
  - Release -> vectors 1..5 emerge in order on consecutive clocks, none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,1,0,1 with out_ready=1 -> out_valid pattern is identical, delayed by 3 clocks.
- Reset mid-op: fill the pipeline with 3 vectors, pulse rst for 1 cycle between clock edges -> out_valid=0, all x=0 immediately. First output after reset comes from the first vector accepted after reset.
